// File: rtl/int_arbiter.sv
// int_arbiter: latches CLINT pulses and a synchronised external line into pending bits,
// masks them, and hands the highest-priority cause to the core over a req/ack handshake.
module int_arbiter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        INT_EN,
    input  logic [3:0]  INT_CODE,
    input  logic        EXT_IRQ,
    input  logic        MSTATUS_IE,
    input  logic [31:0] MIE_CSR,
    input  logic        TRAP_ACK,
    output logic        TRAP_REQ,
    output logic [3:0]  TRAP_CODE,
    output logic [31:0] MIP
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             code_q, code_d;
    logic                   msip_q, msip_d, mtip_q, mtip_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   meip, ack_fire;
    logic [2:0]             en;
    logic                   unused_mie;

    assign unused_mie = ^{MIE_CSR[31:12], MIE_CSR[10:8], MIE_CSR[6:4], MIE_CSR[2:0]};
    assign meip       = sync_q[SYNC_STAGES-1];
    assign ack_fire   = (state_q == REQ) && TRAP_ACK;
    assign en         = {meip, msip_q, mtip_q} & {MIE_CSR[11], MIE_CSR[3], MIE_CSR[7]} & {3{MSTATUS_IE}};

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], EXT_IRQ};
        // a fresh pulse overrides a same-cycle ack so the event is not lost
        msip_d  = (INT_EN && INT_CODE == 4'd3) || (msip_q && !(ack_fire && code_q == 4'd3));
        mtip_d  = (INT_EN && INT_CODE == 4'd7) || (mtip_q && !(ack_fire && code_q == 4'd7));
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            IDLE: if (|en) begin
                state_d = REQ;
                code_d  = en[2] ? 4'd11 : en[1] ? 4'd3 : 4'd7;
            end
            REQ:  state_d = TRAP_ACK ? HOLD : REQ;
            HOLD: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            code_q  <= 4'd0;
            msip_q  <= 1'b0;
            mtip_q  <= 1'b0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            msip_q  <= msip_d;
            mtip_q  <= mtip_d;
            sync_q  <= sync_d;
        end
    end

    assign TRAP_REQ  = (state_q == REQ);
    assign TRAP_CODE = code_q;
    assign MIP       = {20'b0, meip, 3'b0, mtip_q, 3'b0, msip_q, 3'b0};
endmodule

// File: tb/tb_int_arbiter.sv
// tb_int_arbiter: directed checks of pending latching, priority, masking, handshake and async reset.
module tb_int_arbiter;
    logic        CLK = 0, RST_N = 0, INT_EN = 0, EXT_IRQ = 0, MSTATUS_IE = 0, TRAP_ACK = 0;
    logic [3:0]  INT_CODE = 0;
    logic [31:0] MIE_CSR = 0;
    logic        TRAP_REQ;
    logic [3:0]  TRAP_CODE;
    logic [31:0] MIP;
    int checks = 0, errors = 0;

    always #5 CLK = ~CLK;

    int_arbiter #(.SYNC_STAGES(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .INT_EN(INT_EN), .INT_CODE(INT_CODE), .EXT_IRQ(EXT_IRQ),
        .MSTATUS_IE(MSTATUS_IE), .MIE_CSR(MIE_CSR), .TRAP_ACK(TRAP_ACK),
        .TRAP_REQ(TRAP_REQ), .TRAP_CODE(TRAP_CODE), .MIP(MIP)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic pulse(input logic [3:0] c);
        INT_EN = 1; INT_CODE = c;
        tick();
        INT_EN = 0; INT_CODE = 0;
    endtask

    task automatic ack();
        TRAP_ACK = 1;
        tick();
        TRAP_ACK = 0;
    endtask

    initial begin
        tick(2);
        chk("rst_req", TRAP_REQ, 0);
        chk("rst_code", TRAP_CODE, 0);
        chk("rst_mip", MIP, 0);
        RST_N = 1; MIE_CSR = 32'h888; MSTATUS_IE = 1;
        tick(3);
        // T1
        pulse(3);
        chk("t1_mip", MIP, 32'h8);
        chk("t1_req_early", TRAP_REQ, 0);
        tick();
        chk("t1_req", TRAP_REQ, 1);
        chk("t1_code", TRAP_CODE, 3);
        tick(2);
        chk("t1_req_held", TRAP_REQ, 1);
        ack();
        chk("t1_mip_clr", MIP, 0);
        chk("t1_hold", TRAP_REQ, 0);
        tick();
        chk("t1_idle", TRAP_REQ, 0);
        tick();
        chk("t1_idle2", TRAP_REQ, 0);
        // T2
        MSTATUS_IE = 0;
        pulse(3);
        pulse(7);
        EXT_IRQ = 1;
        tick(3);
        chk("t2_mip_all", MIP, 32'h888);
        chk("t2_masked", TRAP_REQ, 0);
        MSTATUS_IE = 1;
        tick();
        chk("t2_req11", TRAP_REQ, 1);
        chk("t2_code11", TRAP_CODE, 11);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_stable", {TRAP_REQ, TRAP_CODE}, {1'b1, 4'd11});
        end
        ack();
        MSTATUS_IE = 0; EXT_IRQ = 0;
        chk("t2_hold11", TRAP_REQ, 0);
        chk("t2_meip_kept", MIP, 32'h888);
        tick(2);
        chk("t2_mip_noext", MIP, 32'h88);
        MSTATUS_IE = 1;
        tick();
        chk("t2_code3", {TRAP_REQ, TRAP_CODE}, {1'b1, 4'd3});
        ack();
        MSTATUS_IE = 0;
        chk("t2_mip_msiclr", MIP, 32'h80);
        tick();
        MSTATUS_IE = 1;
        chk("t2_idle", TRAP_REQ, 0);
        tick();
        chk("t2_code7", {TRAP_REQ, TRAP_CODE}, {1'b1, 4'd7});
        ack();
        chk("t2_mip_empty", MIP, 0);
        tick(2);
        chk("t2_done", TRAP_REQ, 0);
        // T3
        MSTATUS_IE = 0;
        pulse(7);
        chk("t3_mip", MIP, 32'h80);
        tick(2);
        chk("t3_masked", TRAP_REQ, 0);
        MSTATUS_IE = 1;
        tick();
        chk("t3_req", {TRAP_REQ, TRAP_CODE}, {1'b1, 4'd7});
        MIE_CSR = 32'h808;
        tick(2);
        chk("t3_mie_drop", {TRAP_REQ, TRAP_CODE}, {1'b1, 4'd7});
        MSTATUS_IE = 0;
        tick();
        chk("t3_ie_drop", TRAP_REQ, 1);
        ack();
        chk("t3_mip_clr", MIP, 0);
        MIE_CSR = 32'h888; MSTATUS_IE = 1;
        tick(2);
        // T4
        pulse(7);
        tick();
        chk("t4_req", {TRAP_REQ, TRAP_CODE}, {1'b1, 4'd7});
        TRAP_ACK = 1; INT_EN = 1; INT_CODE = 7;
        tick();
        TRAP_ACK = 0; INT_EN = 0; INT_CODE = 0;
        chk("t4_setwins", MIP, 32'h80);
        chk("t4_hold", TRAP_REQ, 0);
        tick();
        chk("t4_idle", TRAP_REQ, 0);
        tick();
        chk("t4_rereq", {TRAP_REQ, TRAP_CODE}, {1'b1, 4'd7});
        ack();
        chk("t4_clr", MIP, 0);
        tick(2);
        // T5
        pulse(0);
        chk("t5_code0", MIP, 0);
        pulse(5);
        chk("t5_code5", MIP, 0);
        pulse(15);
        chk("t5_code15", {TRAP_REQ, MIP[30:0]}, 0);
        MSTATUS_IE = 0;
        pulse(7);
        ack();
        chk("t5_stray_ack", MIP, 32'h80);
        chk("t5_stray_req", TRAP_REQ, 0);
        pulse(5);
        pulse(15);
        chk("t5_junk_kept", MIP, 32'h80);
        // T6
        MSTATUS_IE = 1;
        tick();
        chk("t6_req", TRAP_REQ, 1);
        EXT_IRQ = 1;
        #3 RST_N = 0;
        #1;
        chk("t6_async_req", TRAP_REQ, 0);
        chk("t6_async_mip", MIP, 0);
        tick(2);
        RST_N = 1;
        tick();
        chk("t6_e1", TRAP_REQ, 0);
        tick();
        chk("t6_e2", TRAP_REQ, 0);
        chk("t6_meip", MIP, 32'h800);
        tick();
        chk("t6_e3", {TRAP_REQ, TRAP_CODE}, {1'b1, 4'd11});
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
